// File: rtl/column_multisrc_l1route_pipe_if.sv
// rtl/column_multisrc_l1route_pipe_if.sv - request/response bus of the column-wise L1 circular-shift router
interface column_multisrc_l1route_pipe_if #(
  parameter int QUAN_SIZE        = 3,
  parameter int STRIDE_UNIT_SIZE = 51,
  parameter int STRIDE_WIDTH     = 5,
  parameter int SRC_NUM          = 2,
  parameter int SHIFT_W          = $clog2(STRIDE_UNIT_SIZE),
  parameter int SRC_W            = $clog2(SRC_NUM)
);
  localparam int SLICE_W = STRIDE_WIDTH * QUAN_SIZE * STRIDE_UNIT_SIZE;

  logic                            in_valid_i;
  logic                            in_ready_o;
  logic                            burst_i;
  logic [SRC_W-1:0]                src_sel_i;
  logic [STRIDE_WIDTH*SHIFT_W-1:0] shift_i;
  logic [SRC_NUM*SLICE_W-1:0]      msg_i;
  logic                            out_valid_o;
  logic                            out_ready_i;
  logic [SRC_W-1:0]                out_src_o;
  logic                            out_last_o;
  logic [SLICE_W-1:0]              msg_o;
  logic                            err_o;

  modport slave (
    input  in_valid_i, burst_i, src_sel_i, shift_i, msg_i, out_ready_i,
    output in_ready_o, out_valid_o, out_src_o, out_last_o, msg_o, err_o
  );

  modport master (
    output in_valid_i, burst_i, src_sel_i, shift_i, msg_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_src_o, out_last_o, msg_o, err_o
  );
endinterface

// File: rtl/column_multisrc_l1route_pipe.sv
// rtl/column_multisrc_l1route_pipe.sv - two-stage column L1 router: source select, per-group rotate, burst replay
// Optional out-of-range shift flag enabled by defining L1ROUTE_SHIFT_CHECK_EN.
module column_multisrc_l1route_pipe #(
  parameter int QUAN_SIZE        = 3,
  parameter int STRIDE_UNIT_SIZE = 51,
  parameter int STRIDE_WIDTH     = 5,
  parameter int SRC_NUM          = 2,
  parameter int SHIFT_W          = $clog2(STRIDE_UNIT_SIZE),
  parameter int SRC_W            = $clog2(SRC_NUM)
) (
  input logic                          sys_clk,
  input logic                          rst,
  column_multisrc_l1route_pipe_if.slave bus
);
  localparam int Z       = STRIDE_UNIT_SIZE;
  localparam int SLICE_W = STRIDE_WIDTH * QUAN_SIZE * Z;
  localparam int SHV_W   = STRIDE_WIDTH * SHIFT_W;

  localparam logic [0:0]         ST_IDLE  = 1'b0;
  localparam logic [0:0]         ST_BURST = 1'b1;
  localparam logic [SRC_W-1:0]   SRC_MAX  = SRC_W'(SRC_NUM - 1);
  localparam logic [SRC_W:0]     SRC_LIM  = (SRC_W + 1)'(SRC_NUM);
  localparam logic [SHIFT_W:0]   Z_EXT    = (SHIFT_W + 1)'(Z);
  localparam logic [SHIFT_W-1:0] Z_LO     = SHIFT_W'(Z);

  logic [0:0]         r_state;
  logic [SRC_W-1:0]   r_cnt;
  logic [SHV_W-1:0]   r_shift_lat;
  logic               r_s1_valid, r_s1_last, r_s2_valid, r_s2_last;
  logic [SRC_W-1:0]   r_s1_src, r_s2_src;
  logic [SLICE_W-1:0] r_s1_msg, r_s2_msg;
  logic [SHV_W-1:0]   r_s1_shift;

  logic               w_en, w_idle, w_accept, w_issue, w_last;
  logic [SRC_W-1:0]   w_src;
  logic [SHV_W-1:0]   w_shift_raw, w_shift_red;
  logic [SLICE_W-1:0] w_sel_msg, w_rot;

  // out[j] = in[(j+s) mod Z] is the low half of the doubled plane shifted right by s
  function automatic logic [Z-1:0] rot_plane(input logic [Z-1:0] v, input logic [SHIFT_W-1:0] s);
    logic [2*Z-1:0] d;
    d = {v, v} >> s;
    return d[Z-1:0];
  endfunction

  assign w_en        = ~r_s2_valid | bus.out_ready_i;
  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle & w_en & bus.in_valid_i;
  assign w_issue     = w_accept | (~w_idle & w_en);
  assign w_shift_raw = w_idle ? bus.shift_i : r_shift_lat;
  assign w_sel_msg   = bus.msg_i[int'(w_src) * SLICE_W +: SLICE_W];

  always_comb begin
    w_src  = '0;
    w_last = 1'b0;
    if (!w_idle) begin
      w_src  = r_cnt;
      w_last = (r_cnt == SRC_MAX);
    end else if (!bus.burst_i) begin
      w_src  = ({1'b0, bus.src_sel_i} >= SRC_LIM) ? SRC_MAX : bus.src_sel_i;
      w_last = 1'b1;
    end
  end

  // factors are below 2Z, so one conditional subtraction is a full mod-Z reduction
  always_comb begin
    w_shift_red = '0;
    for (int g = 0; g < STRIDE_WIDTH; g++) begin
      if ({1'b0, w_shift_raw[g*SHIFT_W +: SHIFT_W]} >= Z_EXT)
        w_shift_red[g*SHIFT_W +: SHIFT_W] = w_shift_raw[g*SHIFT_W +: SHIFT_W] - Z_LO;
      else
        w_shift_red[g*SHIFT_W +: SHIFT_W] = w_shift_raw[g*SHIFT_W +: SHIFT_W];
    end
  end

  always_comb begin
    w_rot = '0;
    for (int g = 0; g < STRIDE_WIDTH; g++)
      for (int b = 0; b < QUAN_SIZE; b++)
        w_rot[(g*QUAN_SIZE+b)*Z +: Z] = rot_plane(r_s1_msg[(g*QUAN_SIZE+b)*Z +: Z],
                                                  r_s1_shift[g*SHIFT_W +: SHIFT_W]);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift_lat <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_src    <= '0;
      r_s1_last   <= 1'b0;
      r_s1_msg    <= '0;
      r_s1_shift  <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_src    <= '0;
      r_s2_last   <= 1'b0;
      r_s2_msg    <= '0;
    end else begin
      if (w_accept && bus.burst_i) begin
        r_state     <= ST_BURST;
        r_cnt       <= SRC_W'(1);
        r_shift_lat <= bus.shift_i;
      end else if (!w_idle && w_en) begin
        if (r_cnt == SRC_MAX) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // both stages advance together so a stalled output never loses the beat behind it
      if (w_en) begin
        r_s1_valid <= w_issue;
        r_s1_src   <= w_src;
        r_s1_last  <= w_last;
        r_s1_msg   <= w_sel_msg;
        r_s1_shift <= w_shift_red;
        r_s2_valid <= r_s1_valid;
        r_s2_src   <= r_s1_src;
        r_s2_last  <= r_s1_last;
        r_s2_msg   <= w_rot;
      end
    end
  end

  assign bus.in_ready_o  = w_en & w_idle;
  assign bus.out_valid_o = r_s2_valid;
  assign bus.out_src_o   = r_s2_src;
  assign bus.out_last_o  = r_s2_last;
  assign bus.msg_o       = r_s2_msg;

`ifdef L1ROUTE_SHIFT_CHECK_EN
  logic r_err;
  logic w_shift_oor;

  always_comb begin
    w_shift_oor = 1'b0;
    for (int g = 0; g < STRIDE_WIDTH; g++)
      if ({1'b0, bus.shift_i[g*SHIFT_W +: SHIFT_W]} >= Z_EXT) w_shift_oor = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) r_err <= 1'b0;
    else if (w_accept && w_shift_oor) r_err <= 1'b1;
  end

  assign bus.err_o = r_err;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule
